// File: rtl/cscv2_uart_pkg.sv
// Shared types and constants for the CSCv2 character UART transmitter.
package cscv2_uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_IDX_W = 3;
    localparam int unsigned BAUD_W    = 16;
    localparam logic        TXD_IDLE  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Character byte as written by the CPU: A nibble high, B nibble low.
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } char_t;

endpackage

// File: rtl/cscv2_uart_tx_if.sv
// CPU-side character write port and status of the UART transmitter.
interface cscv2_uart_tx_if;
    import cscv2_uart_pkg::*;

    logic  wr;
    char_t wdata;
    logic  busy;
    logic  full;
    logic  overflow;

    modport master (output wr, output wdata, input busy, input full, input overflow);
    modport slave  (input wr, input wdata, output busy, output full, output overflow);

endinterface

// File: rtl/cscv2_uart_fifo.sv
// Circular byte buffer; pointers carry an extra wrap bit to tell full from empty.
module cscv2_uart_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read behind the write pointer.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cscv2_uart_tx.sv
// Buffers CPU character writes and serialises them as 8N1 frames on txd.
module cscv2_uart_tx
    import cscv2_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    cscv2_uart_tx_if.slave  bus,
    output logic            txd
);

    tx_state_e              state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [BIT_IDX_W-1:0]   bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   txd_q, txd_d;
    logic                   overflow_q, overflow_d;
    logic                   push, pop, baud_done;
    logic                   fifo_empty, fifo_full;
    logic [DATA_BITS-1:0]   fifo_dout;

    // Space is judged on the pre-edge full flag, so a same-edge pop never admits a write.
    assign push = bus.wr && !fifo_full;

    cscv2_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (bus.wdata),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        overflow_d = overflow_q | (bus.wr & fifo_full);

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                baud_d = baud_q + BAUD_W'(1);
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                baud_d = baud_q + BAUD_W'(1);
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_IDX_W'(DATA_BITS - 1)) state_d = ST_STOP;
                    else                                    bit_d   = bit_q + BIT_IDX_W'(1);
                end
            end
            ST_STOP: begin
                baud_d = baud_q + BAUD_W'(1);
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more bytes wait.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        bit_d   = '0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        unique case (state_d)
            ST_START: txd_d = ~TXD_IDLE;
            ST_DATA:  txd_d = shift_d[0];
            default:  txd_d = TXD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            txd_q      <= TXD_IDLE;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            overflow_q <= overflow_d;
        end
    end

    assign txd          = txd_q;
    assign bus.full     = fifo_full;
    assign bus.overflow = overflow_q;
    assign bus.busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_cscv2_uart_tx.sv
// Directed bench for cscv2_uart_tx at 16 and 1 clocks per bit.
module tb_cscv2_uart_tx;
    import cscv2_uart_pkg::*;

    logic clk;
    logic reset_n;
    logic txd16, txd1;
    int   n_checks;
    int   n_fail;

    cscv2_uart_tx_if if16();
    cscv2_uart_tx_if if1();

    cscv2_uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut16 (
        .clk(clk), .reset_n(reset_n), .bus(if16.slave), .txd(txd16)
    );

    cscv2_uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1.slave), .txd(txd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after the edge that starts the frame; returns 1 unit after the edge ending it.
    task automatic rx_frame(input int sel, input int n, input logic [7:0] b, input string tag);
        logic [9:0] exp_f, obs;
        logic       t, bz;
        int         bad, busy_lo;
        exp_f   = {1'b1, b, 1'b0};
        obs     = '0;
        bad     = 0;
        busy_lo = 0;
        for (int p = 0; p < 10; p++) begin
            for (int c = 0; c < n; c++) begin
                t  = (sel != 0) ? txd1 : txd16;
                bz = (sel != 0) ? if1.busy : if16.busy;
                if (c == n / 2) obs[p] = t;
                if (t !== exp_f[p]) bad++;
                if (bz !== 1'b1) busy_lo++;
                tick();
            end
        end
        check({tag, "_bits"}, 32'(obs), 32'(exp_f));
        check({tag, "_glitch"}, 32'(bad), 32'd0);
        check({tag, "_busy"}, 32'(busy_lo), 32'd0);
    endtask

    task automatic write16(input logic [7:0] b);
        if16.wdata = b;
        if16.wr    = 1'b1;
        tick();
        if16.wr    = 1'b0;
    endtask

    task automatic write1(input logic [7:0] b);
        if1.wdata = b;
        if1.wr    = 1'b1;
        tick();
        if1.wr    = 1'b0;
    endtask

    logic [7:0] burst [6];
    int         lows16, lows1;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        burst[0] = 8'h48; burst[1] = 8'h69; burst[2] = 8'h21;
        burst[3] = 8'h0D; burst[4] = 8'h0A; burst[5] = 8'h55;

        reset_n   = 1'b0;
        if16.wr   = 1'b0;
        if16.wdata = '0;
        if1.wr    = 1'b0;
        if1.wdata = '0;
        repeat (3) tick();
        check("rst_txd", 32'(txd16), 32'd1);
        check("rst_busy", 32'(if16.busy), 32'd0);
        check("rst_full", 32'(if16.full), 32'd0);
        check("rst_ovf", 32'(if16.overflow), 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();

        // Single byte: start bit from edge k+1, busy drops at edge k+161.
        write16(8'h41);
        check("single_no_early", 32'(txd16), 32'd1);
        check("single_busy_k", 32'(if16.busy), 32'd1);
        tick();
        rx_frame(0, 16, 8'h41, "single41");
        check("single_busy_end", 32'(if16.busy), 32'd0);
        repeat (5) tick();

        // Burst of six into a depth-4 buffer: five accepted, sixth dropped.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    if16.wdata = burst[i];
                    if16.wr    = 1'b1;
                    tick();
                    check($sformatf("burst_full_%0d", i), 32'(if16.full), (i >= 4) ? 32'd1 : 32'd0);
                    check($sformatf("burst_ovf_%0d", i), 32'(if16.overflow), (i == 5) ? 32'd1 : 32'd0);
                end
                if16.wr = 1'b0;
            end
            begin
                tick();
                tick();
                for (int i = 0; i < 5; i++) rx_frame(0, 16, burst[i], $sformatf("burst%0d", i));
            end
        join
        check("burst_busy_end", 32'(if16.busy), 32'd0);
        check("burst_full_end", 32'(if16.full), 32'd0);
        check("burst_ovf_sticky", 32'(if16.overflow), 32'd1);
        lows16 = 0;
        for (int c = 0; c < 320; c++) begin
            if (txd16 !== 1'b1) lows16++;
            tick();
        end
        check("burst_no_55", 32'(lows16), 32'd0);

        // Abort during data bit 3 of 0xA5 (bit value 0), then a clean 0x3C.
        write16(8'hA5);
        repeat (70) tick();
        check("abort_pre_txd", 32'(txd16), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("abort_txd", 32'(txd16), 32'd1);
        check("abort_busy", 32'(if16.busy), 32'd0);
        check("abort_full", 32'(if16.full), 32'd0);
        check("abort_ovf", 32'(if16.overflow), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("abort_empty", 32'(if16.busy), 32'd0);
        write16(8'h3C);
        tick();
        rx_frame(0, 16, 8'h3C, "after_abort3C");
        check("after_abort_busy", 32'(if16.busy), 32'd0);

        // One clock per bit: 0xFF frame, then two back-to-back bytes.
        write1(8'hFF);
        check("div1_no_early", 32'(txd1), 32'd1);
        tick();
        rx_frame(1, 1, 8'hFF, "div1_FF");
        check("div1_busy_end", 32'(if1.busy), 32'd0);
        repeat (3) tick();
        fork
            begin
                write1(8'h5A);
                write1(8'hC3);
            end
            begin
                tick();
                tick();
                rx_frame(1, 1, 8'h5A, "div1_5A");
                rx_frame(1, 1, 8'hC3, "div1_C3");
            end
        join
        check("div1_b2b_busy_end", 32'(if1.busy), 32'd0);

        // Reset asserted between edges while random writes are in flight.
        for (int c = 0; c < 300; c++) begin
            if16.wr    = 1'($urandom_range(0, 1));
            if16.wdata = 8'($urandom);
            if1.wr     = 1'($urandom_range(0, 1));
            if1.wdata  = 8'($urandom);
            tick();
        end
        #2 reset_n = 1'b0;
        #1;
        check("rrst_txd16", 32'(txd16), 32'd1);
        check("rrst_busy16", 32'(if16.busy), 32'd0);
        check("rrst_full16", 32'(if16.full), 32'd0);
        check("rrst_ovf16", 32'(if16.overflow), 32'd0);
        check("rrst_txd1", 32'(txd1), 32'd1);
        check("rrst_ovf1", 32'(if1.overflow), 32'd0);
        if16.wr = 1'b0;
        if1.wr  = 1'b0;
        tick();
        reset_n = 1'b1;
        lows16 = 0;
        lows1  = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (txd16 !== 1'b1) lows16++;
            if (txd1 !== 1'b1) lows1++;
        end
        check("rrst_idle16", 32'(lows16), 32'd0);
        check("rrst_idle1", 32'(lows1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
